// File: rtl/tlul_host_arb_pkg.sv
// Shared constants and state type for the two-host TL-UL arbiter.
// Host 0 is the instruction fetch port, host 1 the data port.
package tlul_host_arb_pkg;

   localparam int NumHosts = 2;
   localparam logic HostInstr = 1'b0;
   localparam logic HostData  = 1'b1;

   typedef enum logic {
      ArbIdle,
      ArbHold
   } arb_state_e;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel bundles shared by hosts, arbiter and crossbar.
// Only the fields this slice of the fabric carries are modelled.
package tlul_pkg;

   localparam int TlSrcW = 8;

   typedef struct packed {
      logic              a_valid;
      logic [2:0]        a_opcode;
      logic [2:0]        a_param;
      logic [1:0]        a_size;
      logic [TlSrcW-1:0] a_source;
      logic [31:0]       a_address;
      logic [3:0]        a_mask;
      logic [31:0]       a_data;
      logic              d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic              d_valid;
      logic [2:0]        d_opcode;
      logic [2:0]        d_param;
      logic [1:0]        d_size;
      logic [TlSrcW-1:0] d_source;
      logic              d_sink;
      logic [31:0]       d_data;
      logic              d_error;
      logic              a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb_cnt.sv
// Per-host outstanding request counter for the TL-UL host arbiter.
// Never wraps: it stops at MaxOut and never drops below zero.
module tlul_host_arb_cnt
   import tlul_host_arb_pkg::*;
#(
   parameter int MaxOut = 2,
   parameter int CntW   = $clog2(MaxOut + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            inc,
   input  logic            dec,
   output logic [CntW-1:0] count,
   output logic            at_max
);

   localparam logic [CntW-1:0] Max = CntW'(MaxOut);

   assign at_max = (count == Max);

   // Count issued minus retired; simultaneous inc/dec leaves it unchanged
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count <= '0;
      end else if (inc && !dec && !at_max) begin
         count <= count + 1'b1;
      end else if (dec && !inc && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/tlul_host_arbiter.sv
// Two-host TL-UL arbiter merging instruction and data hosts onto one port.
// Define TLUL_HOST_ARB_RR_EN for round-robin ties; default is data priority.
module tlul_host_arbiter
   import tlul_pkg::*;
   import tlul_host_arb_pkg::*;
#(
   parameter int MaxOutstanding = 2,
   parameter int HostSrcW       = 7
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  tl_h2d_t tl_h_i [NumHosts],
   output tl_d2h_t tl_h_o [NumHosts],
   output tl_h2d_t tl_d_o,
   input  tl_d2h_t tl_d_i,
   output logic    busy_o
);

   localparam int CntW = $clog2(MaxOutstanding + 1);

   arb_state_e          state, state_nxt;
   logic                hold_idx, hold_idx_nxt;
   logic                sel, gnt_vld;
   logic                a_hs, d_hs, d_idx;
   logic [NumHosts-1:0] elig, at_max, inc, dec;
   logic [CntW-1:0]     cnt [NumHosts];
`ifdef TLUL_HOST_ARB_RR_EN
   logic                last_gnt;
`endif

   assign d_idx = tl_d_i.d_source[0];
   assign a_hs  = tl_d_o.a_valid & tl_d_i.a_ready;
   assign d_hs  = tl_d_i.d_valid & tl_h_i[d_idx].d_ready;

   assign elig = {tl_h_i[1].a_valid & ~at_max[1],
                  tl_h_i[0].a_valid & ~at_max[0]};
   assign inc  = {a_hs & sel, a_hs & ~sel};
   assign dec  = {d_hs & d_idx, d_hs & ~d_idx};

   assign busy_o = (cnt[0] != '0) | (cnt[1] != '0) |
                   (state == ArbHold);

   // Pick the granted host: locked while holding, else arbitrate
   always_comb begin
      sel     = HostInstr;
      gnt_vld = 1'b0;
      if (state == ArbHold) begin
         sel     = hold_idx;
         gnt_vld = 1'b1;
      end else begin
         gnt_vld = |elig;
         if (elig[HostInstr] && elig[HostData]) begin
`ifdef TLUL_HOST_ARB_RR_EN
            sel = ~last_gnt;
`else
            sel = HostData;
`endif
         end else if (elig[HostData]) begin
            sel = HostData;
         end else begin
            sel = HostInstr;
         end
      end
   end

   // Forward the granted A channel with the host index tagged in a_source
   always_comb begin
      tl_d_o          = tl_h_i[sel];
      tl_d_o.a_valid  = gnt_vld & tl_h_i[sel].a_valid;
      tl_d_o.a_source = TlSrcW'({tl_h_i[sel].a_source[HostSrcW-1:0], sel});
      tl_d_o.d_ready  = tl_h_i[d_idx].d_ready;
   end

   // Steer D beats by the tag bit and strip it; a_ready only to the grantee
   always_comb begin
      for (int i = 0; i < NumHosts; i++) begin
         tl_h_o[i]          = tl_d_i;
         tl_h_o[i].d_valid  = tl_d_i.d_valid & (d_idx == i[0]);
         tl_h_o[i].d_source = TlSrcW'(tl_d_i.d_source[HostSrcW:1]);
         tl_h_o[i].a_ready  = tl_d_i.a_ready & gnt_vld & (sel == i[0]);
      end
   end

   // Lock onto a stalled grant until its A handshake completes
   always_comb begin
      state_nxt    = state;
      hold_idx_nxt = hold_idx;
      unique case (state)
         ArbIdle: begin
            if (tl_d_o.a_valid && !tl_d_i.a_ready) begin
               state_nxt    = ArbHold;
               hold_idx_nxt = sel;
            end
         end
         ArbHold: begin
            if (a_hs) begin
               state_nxt = ArbIdle;
            end
         end
      endcase
   end

   // Arbiter state and locked host index
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ArbIdle;
         hold_idx <= HostInstr;
      end else begin
         state    <= state_nxt;
         hold_idx <= hold_idx_nxt;
      end
   end

`ifdef TLUL_HOST_ARB_RR_EN
   // Remember the last accepted host so ties alternate
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_gnt <= HostInstr;
      end else if (a_hs) begin
         last_gnt <= sel;
      end
   end
`endif

   tlul_host_arb_cnt #(
      .MaxOut (MaxOutstanding),
      .CntW   (CntW)
   ) u_cnt_instr (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc    (inc[HostInstr]),
      .dec    (dec[HostInstr]),
      .count  (cnt[HostInstr]),
      .at_max (at_max[HostInstr])
   );

   tlul_host_arb_cnt #(
      .MaxOut (MaxOutstanding),
      .CntW   (CntW)
   ) u_cnt_data (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc    (inc[HostData]),
      .dec    (dec[HostData]),
      .count  (cnt[HostData]),
      .at_max (at_max[HostData])
   );

endmodule
